// File: rtl/sponge_absorber_pkg.sv
// Shared constants and FSM state type for the SHA-3 sponge absorber.
// SHA3_DOMAIN_PAD_EN selects the FIPS 202 first pad byte (0x06) over original Keccak (0x01).
package sha3_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

`ifdef SHA3_DOMAIN_PAD_EN
  localparam logic [7:0] PAD_FIRST = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST = 8'h01;
`endif
  localparam logic [7:0] PAD_LAST = 8'h80;

  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    START,
    WAIT_PERM
  } absorb_state_t;

endpackage

// File: rtl/sponge_absorber_if.sv
// Message stream, lane XOR-write bus and permutation handshake of the sponge absorber.
// The master side is the absorber; the slave side is the message source plus permutation.
interface sponge_absorber_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [sha3_pkg::LANE_W-1:0]   in_data;
  logic                          in_last;
  logic [3:0]                    in_bytes;

  logic                          state_clear;
  logic                          lane_we;
  logic [4:0]                    lane_idx;
  logic [sha3_pkg::LANE_W-1:0]   lane_data;
  logic                          perm_start;
  logic                          perm_done;
  logic                          msg_done;
  logic                          busy;

  modport master (
    input  in_valid, in_data, in_last, in_bytes, perm_done,
    output in_ready, state_clear, lane_we, lane_idx, lane_data,
           perm_start, msg_done, busy
  );

  modport slave (
    output in_valid, in_data, in_last, in_bytes, perm_done,
    input  in_ready, state_clear, lane_we, lane_idx, lane_data,
           perm_start, msg_done, busy
  );

endinterface

// File: rtl/sponge_absorber_pad_lane.sv
// Combinational pad10*1 lane former shared by message lanes and pure pad lanes.
// Bytes below nbytes pass through, the first pad byte lands at nbytes, the rest are zero.
module pad_lane
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] data,
  input  logic [3:0]        nbytes,
  input  logic              is_last,
  input  logic              first_pad,
  input  logic              final_lane,
  output logic [LANE_W-1:0] lane
);

  logic [3:0] n_keep;

  always_comb begin
    n_keep = (!is_last || nbytes > 4'd8) ? 4'd8 : nbytes;
    lane   = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n_keep) begin
        lane[8*k +: 8] = data[8*k +: 8];
      end else if (4'(k) == n_keep && first_pad) begin
        lane[8*k +: 8] = PAD_FIRST;
      end
    end
    // Closing pad bit is ORed so it can share byte 7 with the first pad byte.
    if (final_lane) begin
      lane[LANE_W-1 -: 8] = lane[LANE_W-1 -: 8] | PAD_LAST;
    end
  end

endmodule

// File: rtl/sponge_absorber.sv
// Sponge absorber: pads a 64-bit lane stream with pad10*1 and feeds rate blocks to Keccak-f.
// First pad byte depends on SHA3_DOMAIN_PAD_EN (0x06 when defined, 0x01 otherwise).
module sponge_absorber #(
  parameter int RATE_LANES = 17,
  parameter int LANE_W     = 64
) (
  input  logic                clock,
  input  logic                reset,
  sponge_absorber_if.master   bus
);

  import sha3_pkg::*;

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  absorb_state_t       state;
  logic [4:0]          cnt;
  logic                pad_done;
  logic                pad_pending;

  logic [LANE_W-1:0]   pl_data;
  logic [3:0]          pl_nbytes;
  logic                pl_is_last;
  logic                pl_first_pad;
  logic                pl_final_lane;
  logic [LANE_W-1:0]   padded;
  logic                fill_pads;

  assign fill_pads = bus.in_last && (bus.in_bytes < 4'd8);

  // PAD lanes are all-zero data; only a pending pad byte or the closing bit marks them.
  always_comb begin
    pl_data       = '0;
    pl_nbytes     = 4'd0;
    pl_is_last    = 1'b1;
    pl_first_pad  = pad_pending;
    pl_final_lane = (cnt == LAST_LANE);
    if (state == FILL) begin
      pl_data       = bus.in_data;
      pl_nbytes     = bus.in_bytes;
      pl_is_last    = bus.in_last;
      pl_first_pad  = fill_pads;
      pl_final_lane = fill_pads && (cnt == LAST_LANE);
    end
  end

  pad_lane u_pad_lane (
    .data       (pl_data),
    .nbytes     (pl_nbytes),
    .is_last    (pl_is_last),
    .first_pad  (pl_first_pad),
    .final_lane (pl_final_lane),
    .lane       (padded)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      pad_done        <= 1'b0;
      pad_pending     <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.state_clear <= 1'b0;
      bus.lane_we     <= 1'b0;
      bus.lane_idx    <= '0;
      bus.lane_data   <= '0;
      bus.perm_start  <= 1'b0;
      bus.msg_done    <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.state_clear <= 1'b0;
      bus.lane_we     <= 1'b0;
      bus.perm_start  <= 1'b0;
      bus.msg_done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state           <= FILL;
            cnt             <= '0;
            pad_done        <= 1'b0;
            pad_pending     <= 1'b0;
            bus.state_clear <= 1'b1;
            bus.in_ready    <= 1'b1;
            bus.busy        <= 1'b1;
          end
        end
        FILL: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.lane_we   <= 1'b1;
            bus.lane_idx  <= cnt;
            bus.lane_data <= padded;
            cnt           <= cnt + 5'd1;
            if (bus.in_last) begin
              if (fill_pads) pad_done    <= 1'b1;
              else           pad_pending <= 1'b1;
            end
            if (cnt == LAST_LANE) begin
              state        <= START;
              bus.in_ready <= 1'b0;
            end else if (bus.in_last) begin
              state        <= PAD;
              bus.in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          bus.lane_we   <= 1'b1;
          bus.lane_idx  <= cnt;
          bus.lane_data <= padded;
          cnt           <= cnt + 5'd1;
          pad_pending   <= 1'b0;
          pad_done      <= 1'b1;
          if (cnt == LAST_LANE) state <= START;
        end
        START: begin
          bus.perm_start <= 1'b1;
          state          <= WAIT_PERM;
        end
        WAIT_PERM: begin
          // A still-pending pad means the message ended exactly on a block boundary.
          if (bus.perm_done) begin
            cnt <= '0;
            if (pad_pending) begin
              state <= PAD;
            end else if (pad_done) begin
              state        <= IDLE;
              bus.msg_done <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              state        <= FILL;
              bus.in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sponge_absorber.md
Name: sponge_absorber

Overview:
- Upstream stage of the Keccak-f[1600] permutation controller (round engine: theta/rho/pi/chi/iota sequencer).
- Takes the message as a stream of 64-bit lanes and applies SHA-3 pad10*1 padding.
- Emits rate-lane XOR writes into the permutation's 25-lane state file.
- Issues one permutation start per rate block and waits for completion before absorbing the next block.

Parameters:
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256, 18 = SHA3-224, 13 = SHA3-384, 9 = SHA3-512, 21 = SHAKE128); legal range 2..24.
- LANE_W, 64, lane width in bits; fixed at 64, present for readability only.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  64  message bytes, little-endian: byte k = bits [8k+7:8k]
- in_last  in  1  final word of the message
- in_bytes  in  4  valid bytes in the last word, 0..8; ignored when in_last=0; values >8 treated as 8
- state_clear  out  1  one-cycle pulse: the consumer zeroes all 25 state lanes
- lane_we  out  1  lane XOR-write strobe
- lane_idx  out  5  target lane 0..RATE_LANES-1
- lane_data  out  64  value the consumer XORs into state[lane_idx]
- perm_start  out  1  one-cycle pulse: run 24 rounds
- perm_done  in  1  permutation finished; sampled only in WAIT_PERM
- msg_done  out  1  one-cycle pulse after the final block's permutation
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: every output is 0, the FSM returns to IDLE, and the lane counter and pad flags are 0. Reset from any state, including WAIT_PERM, aborts with no further strobes.
- All outputs are registered. lane_we/lane_idx/lane_data appear in the cycle after the word is accepted.
- IDLE:
  - in_ready=0.
  - When in_valid=1: pulse state_clear, then go to FILL.
  - The word is not consumed in IDLE.
- FILL:
  - in_ready=1.
  - Each accepted word produces lane_we=1, lane_idx=cnt, then cnt++.
  - A non-last word is written unchanged.
  - A last word with in_bytes=n<8 has bytes 0..n-1 kept, byte n = 0x06 and higher bytes 0, and sets pad_done.
  - A last word with n=8 is written unchanged and sets pad_pending.
  - If a padded word lands in lane RATE_LANES-1, byte 7 is additionally ORed with 0x80 (n=7 gives byte 7 = 0x86).
  - When cnt reaches RATE_LANES: go to START.
  - When in_last is accepted with cnt<RATE_LANES-1 (pad_done or pad_pending set): go to PAD.
- PAD:
  - in_ready=0.
  - Emit one lane per cycle until lane RATE_LANES-1 is written.
  - The first lane written in PAD is 0x06 if pad_pending is set, else 0.
  - The lane at RATE_LANES-1 is ORed with 0x8000_0000_0000_0000.
  - Then go to START.
- START:
  - perm_start=1 for one cycle, then go to WAIT_PERM.
  - The cycle before perm_start is the last lane write, so perm_start never coincides with lane_we.
- WAIT_PERM:
  - in_ready=0; hold until perm_done=1, then reset cnt to 0.
  - If the block held no pad: go to FILL.
  - If pad_pending was set and the block ended exactly at the boundary: go to PAD for a full pad block (lane 0 = 0x06, lane RATE_LANES-1 = 0x80<<56).
  - Otherwise: pulse msg_done and go to IDLE.
- Empty message (first word has in_last=1, in_bytes=0): lane 0 = 0x06; this is one block.
- perm_done asserted outside WAIT_PERM is ignored.
- in_valid may drop in FILL at any time; the FSM holds with no timeout.

Optional Feature:
- Macro SHA3_DOMAIN_PAD_EN.
- Defined: the first pad byte is 0x06 (FIPS 202 SHA-3 domain bits).
- Undefined: the first pad byte is 0x01 (original Keccak padding), and the last-lane value becomes 0x81 when it coincides with the first pad byte.
- All other behaviour is identical.

Decomposition:
- Package sha3_pkg:
  - LANE_W=64, NUM_LANES=25.
  - PAD_FIRST byte (macro-selected), PAD_LAST=8'h80.
  - Rate constants RATE_SHA3_224/256/384/512 and RATE_SHAKE128/256.
  - FSM state enum: IDLE, FILL, PAD, START, WAIT_PERM.
- Sub-module pad_lane: combinational; inputs data, nbytes, is_last, first_pad, final_lane; output the padded 64-bit lane. It is shared by FILL and PAD.

Test Plan:
- Empty message, RATE=17: in_last, in_bytes=0 -> state_clear, lane0=0x06, lanes 1..15=0, lane16=0x8000_0000_0000_0000, one perm_start, msg_done after perm_done.
- 17 full words, last with in_bytes=8 -> 17 data lanes, perm_start; after perm_done a second block (lane0=0x06, lane16=0x80<<56), perm_start, then msg_done. Exactly 2 perm_starts.
- 17 words, last with in_bytes=7, data 0x00AA..AA -> lane16 = 0x86AA_AAAA_AAAA_AAAA, single block, msg_done.
- perm_done delayed 40 cycles, in_valid held high -> in_ready=0 throughout WAIT_PERM; no lane_we until the cycle after perm_done+1; no word lost.
- reset asserted in WAIT_PERM and in PAD -> next cycle all outputs 0, busy=0; a new message then starts with state_clear.
- Macro undefined, 1-byte message 0x41 -> lane0 = 0x0000_0000_0000_0141, lane16 = 0x80<<56.
